// File: rtl/flags_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flags_ctrl_if : host write and maintenance RMW request bus          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface flags_ctrl_if;
    logic        host_wr;
    logic [31:0] host_data;
    logic        mnt_req;
    logic [31:0] mnt_mask;
    logic [31:0] mnt_data;
    logic        mnt_ack;

    modport master (
        output host_wr,
        output host_data,
        output mnt_req,
        output mnt_mask,
        output mnt_data,
        input  mnt_ack
    );

    modport slave (
        input  host_wr,
        input  host_data,
        input  mnt_req,
        input  mnt_mask,
        input  mnt_data,
        output mnt_ack
    );
endinterface
`default_nettype wire

// File: rtl/flags_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flags_ctrl : capture FSM and write arbiter for the flags register   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module flags_ctrl #(
    parameter logic [31:0] LOCK_MASK    = 32'h0000_01FF,
    parameter int          FLUSH_CYCLES = 4,
    parameter int          RLE_BIT      = 8
) (
    input  logic         clk,
    input  logic         rst,
    flags_ctrl_if.slave  bus,
    input  logic         arm,
    input  logic         run,
    input  logic         capture_done,
    input  logic         abort,
    output logic         cmd_flags,
    output logic [31:0]  cmd_data,
    output logic         finish_now,
    output logic [31:0]  shadow_flags,
    output logic         cfg_locked,
    output logic         host_pending,
    output logic         host_overrun,
    output logic [1:0]   state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;
    localparam logic [7:0] C_FLUSH_LOAD = 8'(FLUSH_CYCLES);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_cmd_flags;
    logic [31:0] r_cmd_data;
    logic        r_finish;
    logic        r_ack;
    logic [31:0] r_shadow;
    logic        r_locked;
    logic        r_pend_v;
    logic [31:0] r_pend_d;
    logic        r_ovr;

    logic [31:0] w_shadow_eff;
    logic        w_locked;
    logic        w_mnt_ok;
    logic [31:0] w_rmw;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_finish_nxt;
    logic        w_wr;
    logic [31:0] w_wdata;
    logic        w_ack;
    logic        w_pend_v;
    logic [31:0] w_pend_d;
    logic        w_ovr;

    // Value the flags register holds after this edge; RMW merges into it so
    // back-to-back grants and a coincident finish_now are already accounted for.
    always_comb begin
        w_shadow_eff = r_cmd_flags ? r_cmd_data : r_shadow;
        if (r_finish) begin
            w_shadow_eff[RLE_BIT] = 1'b0;
        end
    end

    assign w_locked = (r_state != S_IDLE);
    assign w_mnt_ok = bus.mnt_req &&
                      (!w_locked || ((bus.mnt_mask & LOCK_MASK) == 32'h0));
    assign w_rmw    = (w_shadow_eff & ~bus.mnt_mask) | (bus.mnt_data & bus.mnt_mask);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (abort) begin
                    w_state_nxt  = S_IDLE;
                    w_finish_nxt = 1'b1;
                end else if (run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt  = S_IDLE;
                    w_finish_nxt = 1'b1;
                end else if (capture_done) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = C_FLUSH_LOAD;
                end
            end
            default: begin
                if (abort || (r_cnt == 8'd1)) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = 8'd0;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
        endcase
    end

    // Host path wins in IDLE; while locked it only feeds the one-deep buffer.
    always_comb begin
        w_wr     = 1'b0;
        w_wdata  = r_cmd_data;
        w_ack    = 1'b0;
        w_pend_v = r_pend_v;
        w_pend_d = r_pend_d;
        w_ovr    = r_ovr;
        if (!w_locked && bus.host_wr) begin
            w_wr     = 1'b1;
            w_wdata  = bus.host_data;
            w_pend_v = 1'b0;
        end else if (!w_locked && r_pend_v) begin
            w_wr     = 1'b1;
            w_wdata  = r_pend_d;
            w_pend_v = 1'b0;
        end else if (w_mnt_ok) begin
            w_wr    = 1'b1;
            w_wdata = w_rmw;
            w_ack   = 1'b1;
        end
        if (w_locked && bus.host_wr) begin
            w_ovr    = r_ovr | r_pend_v;
            w_pend_v = 1'b1;
            w_pend_d = bus.host_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_cmd_flags <= 1'b0;
            r_cmd_data  <= 32'h0;
            r_finish    <= 1'b0;
            r_ack       <= 1'b0;
            r_shadow    <= 32'h0;
            r_locked    <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_d    <= 32'h0;
            r_ovr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_flags <= w_wr;
            r_cmd_data  <= w_wdata;
            r_finish    <= w_finish_nxt;
            r_ack       <= w_ack;
            r_shadow    <= w_shadow_eff;
            r_locked    <= (w_state_nxt != S_IDLE);
            r_pend_v    <= w_pend_v;
            r_pend_d    <= w_pend_d;
            r_ovr       <= w_ovr;
        end
    end

    assign bus.mnt_ack   = r_ack;
    assign cmd_flags     = r_cmd_flags;
    assign cmd_data      = r_cmd_data;
    assign finish_now    = r_finish;
    assign shadow_flags  = r_shadow;
    assign cfg_locked    = r_locked;
    assign host_pending  = r_pend_v;
    assign host_overrun  = r_ovr;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_flags_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_flags_ctrl : directed + randomized bench with behavioural model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_flags_ctrl;

    localparam logic [31:0] LOCK_MASK    = 32'h0000_01FF;
    localparam int          FLUSH_CYCLES = 4;
    localparam int          RLE_BIT      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        run = 1'b0;
    logic        capture_done = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_flags;
    logic [31:0] cmd_data;
    logic        finish_now;
    logic [31:0] shadow_flags;
    logic        cfg_locked;
    logic        host_pending;
    logic        host_overrun;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    flags_ctrl_if bus ();

    flags_ctrl #(
        .LOCK_MASK    (LOCK_MASK),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .RLE_BIT      (RLE_BIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .arm          (arm),
        .run          (run),
        .capture_done (capture_done),
        .abort        (abort),
        .cmd_flags    (cmd_flags),
        .cmd_data     (cmd_data),
        .finish_now   (finish_now),
        .shadow_flags (shadow_flags),
        .cfg_locked   (cfg_locked),
        .host_pending (host_pending),
        .host_overrun (host_overrun),
        .state        (state)
    );

    initial forever #5 clk = ~clk;

    // Reference model: capture phase, flags register contents, host buffer,
    // and the outputs that the last edge decided.
    int          m_phase = 0;
    int          m_flush_elapsed = 0;
    logic [31:0] m_flags = 32'h0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pdata = 32'h0;
    logic        m_ovr = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_fin = 1'b0;
    logic        m_ack = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_flush_elapsed = 0; m_flags = 32'h0;
        m_pend = 1'b0; m_pdata = 32'h0; m_ovr = 1'b0;
        m_wr = 1'b0; m_wdata = 32'h0; m_fin = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] landed;
        logic        busy;
        logic        nwr, nack, nfin;
        logic [31:0] ndata;
        landed = m_wr ? m_wdata : m_flags;
        if (m_fin) landed[RLE_BIT] = 1'b0;
        m_flags = landed;
        busy = (m_phase != 0);
        nwr = 1'b0; nack = 1'b0; nfin = 1'b0; ndata = m_wdata;
        if (!busy && bus.host_wr) begin
            nwr = 1'b1; ndata = bus.host_data; m_pend = 1'b0;
        end else if (!busy && m_pend) begin
            nwr = 1'b1; ndata = m_pdata; m_pend = 1'b0;
        end else if (bus.mnt_req && (!busy || (bus.mnt_mask & LOCK_MASK) == 0)) begin
            nwr = 1'b1; nack = 1'b1;
            ndata = (landed & ~bus.mnt_mask) | (bus.mnt_data & bus.mnt_mask);
        end
        if (busy && bus.host_wr) begin
            if (m_pend) m_ovr = 1'b1;
            m_pend = 1'b1; m_pdata = bus.host_data;
        end
        if (m_phase == 0) begin
            if (arm) m_phase = 1;
        end else if (abort) begin
            m_phase = 0; nfin = 1'b1;
        end else if (m_phase == 1) begin
            if (run) m_phase = 2;
        end else if (m_phase == 2) begin
            if (capture_done) begin m_phase = 3; m_flush_elapsed = 0; end
        end else begin
            m_flush_elapsed++;
            if (m_flush_elapsed == FLUSH_CYCLES) begin m_phase = 0; nfin = 1'b1; end
        end
        m_wr = nwr; m_wdata = ndata; m_ack = nack; m_fin = nfin;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        logic [71:0] act, exp;
        @(negedge clk);
        if (!rst) begin
            act = {state, cfg_locked, host_pending, host_overrun, cmd_flags, finish_now,
                   bus.mnt_ack, shadow_flags, (m_wr ? cmd_data : 32'h0)};
            exp = {m_phase[1:0], (m_phase != 0), m_pend, m_ovr, m_wr, m_fin,
                   m_ack, m_flags, (m_wr ? m_wdata : 32'h0)};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL model_compare t=%0t dut=%h model=%h", $time, act, exp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_arm_run();
        arm = 1'b1; tick(); arm = 1'b0;
        run = 1'b1; tick(); run = 1'b0;
    endtask

    initial begin
        int fl;
        bus.host_wr = 1'b0; bus.host_data = 32'h0;
        bus.mnt_req = 1'b0; bus.mnt_mask = 32'h0; bus.mnt_data = 32'h0;
        repeat (3) tick();
        chk("reset_outputs",
            {22'h0, state, cfg_locked, host_pending, host_overrun, cmd_flags, finish_now,
             bus.mnt_ack, (shadow_flags != 0), (cmd_data != 0)}, 32'h0);
        rst = 1'b0;

        // Host write in IDLE
        bus.host_wr = 1'b1; bus.host_data = 32'h0000_0105; tick();
        bus.host_wr = 1'b0;
        chk("host_wr_strobe", {31'h0, cmd_flags}, 32'h1);
        chk("host_wr_data", cmd_data, 32'h0000_0105);
        tick();
        chk("host_wr_shadow", shadow_flags, 32'h0000_0105);

        // Back-to-back maintenance RMW
        bus.mnt_req = 1'b1; bus.mnt_mask = 32'h0000_0F00; bus.mnt_data = 32'h0000_0A00; tick();
        chk("rmw1_ack", {31'h0, bus.mnt_ack}, 32'h1);
        chk("rmw1_data", cmd_data, 32'h0000_0A05);
        bus.mnt_mask = 32'h0000_000F; bus.mnt_data = 32'h0; tick();
        chk("rmw2_ack", {31'h0, bus.mnt_ack}, 32'h1);
        chk("rmw2_data", cmd_data, 32'h0000_0A00);
        bus.mnt_req = 1'b0; tick();
        chk("rmw_shadow", shadow_flags, 32'h0000_0A00);

        // Deferred host writes with overrun, released by abort
        arm = 1'b1; tick(); arm = 1'b0;
        chk("armed_state", {30'h0, state}, 32'h1);
        bus.host_wr = 1'b1; bus.host_data = 32'h1; tick();
        bus.host_data = 32'h2; tick();
        bus.host_wr = 1'b0;
        chk("locked_no_write", {31'h0, cmd_flags}, 32'h0);
        chk("locked_pending_overrun", {30'h0, host_pending, host_overrun}, 32'h3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_finish", {29'h0, finish_now, state}, 32'h4);
        tick();
        chk("pending_issue", {31'h0, cmd_flags}, 32'h1);
        chk("pending_data", cmd_data, 32'h2);
        chk("pending_cleared", {31'h0, host_pending}, 32'h0);
        tick();

        // Locked-bit RMW stalls through FLUSH, then merges into RLE-cleared shadow
        bus.host_wr = 1'b1; bus.host_data = 32'h0000_01F0; tick();
        bus.host_wr = 1'b0; tick();
        pulse_arm_run();
        chk("run_state", {30'h0, state}, 32'h2);
        bus.mnt_req = 1'b1; bus.mnt_mask = 32'h1; bus.mnt_data = 32'h1;
        tick(); tick();
        chk("stall_no_ack", {31'h0, bus.mnt_ack}, 32'h0);
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        fl = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 2'd3) break;
            fl++;
            tick();
        end
        chk("flush_cycles", fl, FLUSH_CYCLES);
        chk("flush_finish", {31'h0, finish_now}, 32'h1);
        tick();
        chk("stall_ack", {31'h0, bus.mnt_ack}, 32'h1);
        chk("stall_rmw_data", cmd_data, 32'h0000_00F1);
        bus.mnt_req = 1'b0; tick();
        chk("stall_shadow", shadow_flags, 32'h0000_00F1);

        // Host write landing in FLUSH, after the finish clears bit 8
        bus.host_wr = 1'b1; bus.host_data = 32'h0000_0100; tick();
        bus.host_wr = 1'b0; tick();
        pulse_arm_run();
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        bus.host_wr = 1'b1; bus.host_data = 32'h0000_0180; tick();
        bus.host_wr = 1'b0;
        chk("flush_pending", {31'h0, host_pending}, 32'h1);
        fl = 0;
        for (int i = 0; i < 20; i++) begin
            if (finish_now) break;
            fl++;
            tick();
        end
        chk("finish_seen", {31'h0, finish_now}, 32'h1);
        tick();
        chk("post_finish_write", {31'h0, cmd_flags}, 32'h1);
        chk("post_finish_data", cmd_data, 32'h0000_0180);
        chk("post_finish_shadow", shadow_flags, 32'h0000_0000);
        tick();
        chk("final_shadow", shadow_flags, 32'h0000_0180);

        // Asynchronous reset during FLUSH with a pending host write
        pulse_arm_run();
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        bus.host_wr = 1'b1; bus.host_data = 32'h55; tick();
        bus.host_wr = 1'b0;
        chk("pre_rst_pending", {29'h0, host_pending, state}, 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {22'h0, state, cfg_locked, host_pending, host_overrun, cmd_flags, finish_now,
             bus.mnt_ack, (shadow_flags != 0), (cmd_data != 0)}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_write", {31'h0, cmd_flags}, 32'h0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            arm          = ($urandom % 6) == 0;
            run          = ($urandom % 6) == 0;
            capture_done = ($urandom % 6) == 0;
            abort        = ($urandom % 25) == 0;
            bus.host_wr   = ($urandom % 5) == 0;
            bus.host_data = $urandom;
            if (bus.mnt_req && bus.mnt_ack) bus.mnt_req = 1'b0;
            if (!bus.mnt_req && ($urandom % 3) == 0) begin
                bus.mnt_req  = 1'b1;
                bus.mnt_mask = ($urandom % 2) ? ($urandom & ~LOCK_MASK) : $urandom;
                bus.mnt_data = $urandom;
            end
            rst = ($urandom % 400) == 0;
            tick();
        end
        rst = 1'b0; arm = 1'b0; run = 1'b0; capture_done = 1'b0; abort = 1'b0;
        bus.host_wr = 1'b0; bus.mnt_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
